instr_issuer: RTL

- Host-side driver for the 16-bit instruction port of the register-file compute unit.
- Accepts instructions as a byte stream (high byte first) and buffers them in a small FIFO.
- On command, issues the buffered instructions back-to-back, one per cycle.
- Captures the compute unit's 8-bit result for each issued instruction and returns it tagged with the target register ID.

---
 rtl/instr_issuer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instr_issuer.sv
// Host-side issuer for the compute unit: assembles instruction bytes into a FIFO,
// issues bursts one per cycle, and returns each result tagged with its target register.
module instr_issuer #(
    parameter int DEPTH      = 8,
    parameter int RESULT_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        run,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic [7:0]  result_in,
    output logic [7:0]  result_out,
    output logic [3:0]  result_tag,
    output logic        result_valid,
    output logic        busy,
    output logic        empty,
    output logic        full,
    output logic        ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      drain_q;
    logic            issuing;
    logic            phase_lo;
    logic [7:0]      hi_byte;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            full_q, empty_q, ovf_q;
    logic            push, pop;
    logic [15:0]     instr_q;
    logic            instr_vld_q;
    logic [RESULT_LAT-1:0] vld_p;
    logic [3:0]      tag_p [RESULT_LAT];
    logic [7:0]      result_q;
    logic [3:0]      tag_q;
    logic            res_vld_q;

    // A byte is accepted only when the FIFO has room; the low byte completes an entry.
    assign push = ena & byte_valid & ~full_q & phase_lo;
    assign pop  = ena & issuing & ~empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_lo <= 1'b0;
            hi_byte  <= 8'h00;
            ovf_q    <= 1'b0;
        end else if (ena && byte_valid) begin
            if (full_q) begin
                ovf_q <= 1'b1;
            end else if (!phase_lo) begin
                hi_byte  <= byte_in;
                phase_lo <= 1'b1;
            end else begin
                phase_lo <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {hi_byte, byte_in};
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else if (ena) begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            full_q  <= (count_next == CW'(DEPTH));
            empty_q <= (count_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= 3'd0;
        end else if (ena) begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? drain_q + 3'd1 : 3'd0;
        end
    end

    // A push landing in the same cycle as the last pop keeps the burst going.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run && !empty_q) state_d = ISSUE;
            ISSUE:   if (count == CW'(1) && !push) state_d = DRAIN;
            DRAIN:   if (drain_q == 3'(RESULT_LAT)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        issuing = (state_q == ISSUE);
    end

    // Issue stage: popped head or a no-op when nothing is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= 16'h0000;
            instr_vld_q <= 1'b0;
        end else if (ena) begin
            instr_q     <= pop ? mem[rd_ptr] : 16'h0000;
            instr_vld_q <= pop;
        end
    end

    // Result tracking: valid/tag follow each issued instruction for RESULT_LAT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            for (int i = 0; i < RESULT_LAT; i++) tag_p[i] <= 4'h0;
            result_q  <= 8'h00;
            tag_q     <= 4'h0;
            res_vld_q <= 1'b0;
        end else if (ena) begin
            vld_p[0] <= instr_vld_q;
            tag_p[0] <= instr_q[11:8];
            for (int i = 1; i < RESULT_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                tag_p[i] <= tag_p[i-1];
            end
            res_vld_q <= vld_p[RESULT_LAT-1];
            if (vld_p[RESULT_LAT-1]) begin
                result_q <= result_in;
                tag_q    <= tag_p[RESULT_LAT-1];
            end
        end
    end

    assign byte_ready   = ~full_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign ovf_err      = ovf_q;
    assign instr_out    = instr_q;
    assign instr_valid  = instr_vld_q;
    assign result_out   = result_q;
    assign result_tag   = tag_q;
    assign result_valid = res_vld_q & ena;
endmodule
